// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants for the single-clock programmable FIFO.
//   DEFAULT_DATA_WIDTH / DEFAULT_DEPTH : default parameter values
//   ptr_width(depth)                   : memory address width for a depth
// Optional feature macro used by the FIFO: FIFO_FWFT_EN (first-word-fall-through).
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 256;

  // Address width for a power-of-two depth; pointers carry one extra wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DEPTH x DATA_WIDTH storage with one write port and one
// registered read port.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset of the read register only
//   we    : write enable; wdata is stored at waddr
//   waddr : write address
//   wdata : write data
//   re    : read enable; rdata loads the word at raddr
//   raddr : read address
//   rdata : registered read data (old contents on a same-edge write)
// The array itself is never reset.
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with exact occupancy count, programmable
// almost-full / almost-empty thresholds and one-cycle error pulses.
// Optional feature macro: FIFO_FWFT_EN selects first-word-fall-through output;
// without it data_out is a registered read loaded on each accepted read.
//   clk, rst                 : clock (rising edge), async active-high reset
//   w_en, data_in            : write request and data
//   r_en                     : read request
//   af_thresh, ae_thresh     : threshold levels, sampled every cycle
//   data_out                 : read data
//   full, empty              : occupancy flags
//   almost_full, almost_empty: count >= af_thresh, count <= ae_thresh
//   write_error, read_error  : one-cycle pulse after a rejected request
//   count                    : occupancy 0..DEPTH
//
// Request semantics: w_en / r_en are single-cycle requests sampled on each
// rising edge. A read is accepted when the FIFO is not empty. A write is
// accepted when the FIFO is not full, or when a read is accepted on the same
// edge. A rejected request leaves storage and pointers untouched and raises
// the matching error output for exactly the following cycle.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int PTR_WIDTH  = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [PTR_WIDTH:0]    af_thresh,
  input  logic [PTR_WIDTH:0]    ae_thresh,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  write_error,
  output logic                  read_error,
  output logic [PTR_WIDTH:0]    count
);

  logic [PTR_WIDTH:0] wptr, rptr;
  logic [PTR_WIDTH:0] wptr_next, rptr_next, count_next;
  logic               wr_ok, rd_ok;
  logic               mem_re;
  logic [PTR_WIDTH-1:0] mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign rd_ok = r_en && !empty;
  // A read on the same edge frees a slot, so a full FIFO can still accept.
  assign wr_ok = w_en && (!full || rd_ok);

  always_comb begin
    wptr_next  = wptr + {{PTR_WIDTH{1'b0}}, wr_ok};
    rptr_next  = rptr + {{PTR_WIDTH{1'b0}}, rd_ok};
    count_next = count + {{PTR_WIDTH{1'b0}}, wr_ok} - {{PTR_WIDTH{1'b0}}, rd_ok};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      write_error  <= 1'b0;
      read_error   <= 1'b0;
    end else begin
      wptr         <= wptr_next;
      rptr         <= rptr_next;
      count        <= count_next;
      // Same wrap bit -> equal; opposite wrap bit with equal address -> DEPTH apart.
      full         <= (wptr_next[PTR_WIDTH-1:0] == rptr_next[PTR_WIDTH-1:0]) &&
                      (wptr_next[PTR_WIDTH] != rptr_next[PTR_WIDTH]);
      empty        <= (wptr_next == rptr_next);
      almost_full  <= (count_next >= af_thresh);
      almost_empty <= (count_next <= ae_thresh);
      write_error  <= w_en && !wr_ok;
      read_error   <= r_en && !rd_ok;
    end
  end

`ifdef FIFO_FWFT_EN
  // The read port prefetches the head for the post-edge read pointer every
  // cycle. If that slot is being written on the same edge the array still
  // returns the old word, so the written data is captured alongside and
  // selected instead.
  logic                  byp_sel;
  logic [DATA_WIDTH-1:0] byp_data;

  assign mem_re    = 1'b1;
  assign mem_raddr = rptr_next[PTR_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_sel  <= 1'b0;
      byp_data <= '0;
    end else begin
      byp_sel  <= wr_ok && (wptr[PTR_WIDTH-1:0] == rptr_next[PTR_WIDTH-1:0]);
      byp_data <= data_in;
    end
  end

  assign data_out = byp_sel ? byp_data : mem_rdata;
`else
  // Registered read: the output register loads the head only on an accepted
  // read and holds otherwise.
  assign mem_re    = rd_ok;
  assign mem_raddr = rptr[PTR_WIDTH-1:0];
  assign data_out  = mem_rdata;
`endif

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (PTR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wptr[PTR_WIDTH-1:0]),
    .wdata (data_in),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

endmodule
